// File: rtl/jof32_regfile_wb.sv
// JOF32 write-back stage, 2R1W register bank and pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: write-through of the write-back value to the read ports.
module jof32_regfile_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] result_alu_in,
    input  logic [DATA_W-1:0] result_mem_in,
    input  logic [ADDR_W-1:0] dir_wb_in,
    input  logic              sel_wb_in,
    input  logic              reg_wr_in,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              iss_valid,
    input  logic              iss_wr,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              busy_a,
    output logic              busy_b,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              sb_err
);

    localparam int unsigned NumRegs = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [CNT_W-1:0]  cnt_q  [NumRegs];
    logic [CNT_W-1:0]  cnt_d  [NumRegs];
    logic              sb_err_q, sb_err_d;

    always_comb begin
        wb_data_out = sel_wb_in ? result_mem_in : result_alu_in;
    end

    // Matching inc and dec on one register cancel; saturation errors are sticky.
    always_comb begin
        logic inc, dec;
        sb_err_d = sb_err_q;
        for (int i = 0; i < NumRegs; i++) begin
            inc      = iss_valid && iss_wr && (iss_dst == ADDR_W'(i));
            dec      = reg_wr_in && (dir_wb_in == ADDR_W'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                if (cnt_q[i] == CntMax) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (reg_wr_in) begin
                regs_q[dir_wb_in] <= wb_data_out;
            end
            for (int i = 0; i < NumRegs; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (reg_wr_in && (rd_addr_a == dir_wb_in)) begin
            rd_data_a = wb_data_out;
        end
        if (reg_wr_in && (rd_addr_b == dir_wb_in)) begin
            rd_data_b = wb_data_out;
        end
`endif
    end

    always_comb begin
        busy_a = (cnt_q[rd_addr_a] != '0);
        busy_b = (cnt_q[rd_addr_b] != '0);
        sb_err = sb_err_q;
    end

endmodule

// File: tb/tb_jof32_regfile_wb.sv
// Self-checking bench for jof32_regfile_wb: directed scenarios plus random traffic
// compared every cycle against an array/integer model of the register file and scoreboard.
module tb_jof32_regfile_wb;

    localparam int MaxCnt = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] result_alu_in = '0;
    logic [31:0] result_mem_in = '0;
    logic [3:0]  dir_wb_in = '0;
    logic        sel_wb_in = 1'b0;
    logic        reg_wr_in = 1'b0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        iss_valid = 1'b0;
    logic        iss_wr = 1'b0;
    logic [3:0]  iss_dst = '0;
    logic        busy_a, busy_b;
    logic [31:0] wb_data_out;
    logic        sb_err;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_reg [16] = '{default: 32'h0};
    int          m_cnt [16] = '{default: 0};
    logic        m_err = 1'b0;

    jof32_regfile_wb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result_alu_in(result_alu_in),
        .result_mem_in(result_mem_in),
        .dir_wb_in    (dir_wb_in),
        .sel_wb_in    (sel_wb_in),
        .reg_wr_in    (reg_wr_in),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .iss_valid    (iss_valid),
        .iss_wr       (iss_wr),
        .iss_dst      (iss_dst),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .wb_data_out  (wb_data_out),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural state after each commit edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[i] <= 32'h0;
                m_cnt[i] <= 0;
            end
            m_err <= 1'b0;
        end else begin
            if (reg_wr_in) m_reg[dir_wb_in] <= sel_wb_in ? result_mem_in : result_alu_in;
            if (!(iss_valid && iss_wr && reg_wr_in && iss_dst == dir_wb_in)) begin
                if (iss_valid && iss_wr) begin
                    if (m_cnt[iss_dst] == MaxCnt) m_err <= 1'b1;
                    else m_cnt[iss_dst] <= m_cnt[iss_dst] + 1;
                end
                if (reg_wr_in) begin
                    if (m_cnt[dir_wb_in] == 0) m_err <= 1'b1;
                    else m_cnt[dir_wb_in] <= m_cnt[dir_wb_in] - 1;
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] addr);
        logic [31:0] v;
        v = m_reg[addr];
`ifdef REGFILE_BYPASS_EN
        if (reg_wr_in && addr == dir_wb_in) v = sel_wb_in ? result_mem_in : result_alu_in;
`endif
        return v;
    endfunction

    // Per-cycle compare, one step after inputs settle and well away from posedge.
    always begin
        @(negedge clk);
        #2;
        chk("cyc_rd_a", rd_data_a, exp_rd(rd_addr_a));
        chk("cyc_rd_b", rd_data_b, exp_rd(rd_addr_b));
        chk("cyc_busy_a", 32'(busy_a), 32'(m_cnt[rd_addr_a] != 0));
        chk("cyc_busy_b", 32'(busy_b), 32'(m_cnt[rd_addr_b] != 0));
        chk("cyc_wb_data", wb_data_out, sel_wb_in ? result_mem_in : result_alu_in);
        chk("cyc_sb_err", 32'(sb_err), 32'(m_err));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        reg_wr_in = 1'b0;
        iss_valid = 1'b0;
        iss_wr    = 1'b0;
    endtask

    task automatic wb(input logic [3:0] dir, input logic sel, input logic [31:0] alu,
                      input logic [31:0] mem);
        reg_wr_in     = 1'b1;
        dir_wb_in     = dir;
        sel_wb_in     = sel;
        result_alu_in = alu;
        result_mem_in = mem;
    endtask

    task automatic issue(input logic [3:0] dst);
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_dst   = dst;
    endtask

    task automatic reset_pulse();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #6;
        chk("reset_rd_a", rd_data_a, 32'h0);
        chk("reset_busy_a", 32'(busy_a), 32'h0);
        chk("reset_sb_err", 32'(sb_err), 32'h0);
        tick();
        rst_n = 1'b1;

        // Write-back select
        rd_addr_a = 4'd5;
        wb(4'd5, 1'b1, 32'h11, 32'hDEADBEEF);
        #2 chk("wb_sel_mem", wb_data_out, 32'hDEADBEEF);
        tick(); idle();
        #2 chk("r5_mem", rd_data_a, 32'hDEADBEEF);
        wb(4'd5, 1'b0, 32'h11, 32'hDEADBEEF);
        tick(); idle();
        #2 chk("r5_alu", rd_data_a, 32'h00000011);
        sel_wb_in = 1'b0; dir_wb_in = 4'd5; result_alu_in = 32'h55;
        tick();
        #2 chk("r5_nowrite", rd_data_a, 32'h00000011);

        // Same-cycle read of a register being written
        wb(4'd7, 1'b0, 32'h0BAD0007, 32'h0);
        tick();
        rd_addr_b = 4'd7;
        wb(4'd7, 1'b0, 32'hCAFE0001, 32'h0);
`ifdef REGFILE_BYPASS_EN
        #2 chk("bypass_r7", rd_data_b, 32'hCAFE0001);
`else
        #2 chk("nobypass_r7", rd_data_b, 32'h0BAD0007);
`endif
        tick(); idle();
        #2 chk("r7_after", rd_data_b, 32'hCAFE0001);

        // Asynchronous reset mid-cycle
        wb(4'd3, 1'b0, 32'h1234, 32'h0);
        tick(); idle();
        rd_addr_a = 4'd3;
        #2 chk("r3_written", rd_data_a, 32'h1234);
        rst_n = 1'b0;
        #1;
        chk("async_rd_a", rd_data_a, 32'h0);
        chk("async_rd_b", rd_data_b, 32'h0);
        chk("async_busy", 32'({busy_a, busy_b}), 32'h0);
        chk("async_sb_err", 32'(sb_err), 32'h0);
        tick();
        rst_n = 1'b1;

        // Scoreboard saturation and drain
        rd_addr_a = 4'd2;
        issue(4'd2);
        tick(); tick(); tick(); idle();
        #2 chk("sb3_busy", 32'(busy_a), 32'h1);
        chk("sb3_err", 32'(sb_err), 32'h0);
        issue(4'd2);
        tick(); idle();
        #2 chk("sb_ovf_err", 32'(sb_err), 32'h1);
        wb(4'd2, 1'b0, 32'h22, 32'h0);
        tick();
        #2 chk("sb_drain2", 32'(busy_a), 32'h1);
        tick();
        #2 chk("sb_drain1", 32'(busy_a), 32'h1);
        tick(); idle();
        #2 chk("sb_drain0", 32'(busy_a), 32'h0);

        // Simultaneous issue and write-back
        reset_pulse();
        rd_addr_a = 4'd4;
        issue(4'd4);
        tick();
        wb(4'd4, 1'b0, 32'h44, 32'h0);
        tick(); idle();
        #2 chk("simul_busy", 32'(busy_a), 32'h1);
        chk("simul_err", 32'(sb_err), 32'h0);
        wb(4'd4, 1'b0, 32'h45, 32'h0);
        tick(); idle();
        #2 chk("simul_cnt1", 32'(busy_a), 32'h0);
        chk("simul_err2", 32'(sb_err), 32'h0);
        issue(4'd4);
        wb(4'd6, 1'b0, 32'h66, 32'h0);
        rd_addr_b = 4'd6;
        tick(); idle();
        #2 chk("diff_busy4", 32'(busy_a), 32'h1);
        chk("diff_err", 32'(sb_err), 32'h1);
        chk("diff_r6", rd_data_b, 32'h66);
        chk("diff_busy6", 32'(busy_b), 32'h0);

        // Underflow still commits
        reset_pulse();
        rd_addr_a = 4'd9;
        wb(4'd9, 1'b1, 32'h0, 32'h99);
        tick(); idle();
        #2 chk("unf_r9", rd_data_a, 32'h99);
        chk("unf_err", 32'(sb_err), 32'h1);
        chk("unf_busy", 32'(busy_a), 32'h0);

        // Random traffic, checked by the per-cycle compare
        reset_pulse();
        for (int n = 0; n < 3000; n++) begin
            rd_addr_a     = 4'($urandom_range(0, 15));
            rd_addr_b     = 4'($urandom_range(0, 15));
            iss_valid     = ($urandom_range(0, 1) == 1);
            iss_wr        = ($urandom_range(0, 3) != 0);
            iss_dst       = 4'($urandom_range(0, 5));
            reg_wr_in     = ($urandom_range(0, 2) == 0);
            dir_wb_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                        : 4'($urandom_range(0, 5));
            sel_wb_in     = ($urandom_range(0, 1) == 1);
            result_alu_in = $urandom;
            result_mem_in = $urandom;
            if (n % 600 == 599) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
